// File: rtl/hwl_nested_engine.sv
// ---------------------------------------------------------------------------
// hwl_nested_engine
//
// Hardware-loop engine for the uCode sequencer. It watches the retiring PC
// and tells the sequencer when to branch back to the start of a loop body.
// It holds NUM_LOOPS nested loop register sets. Index 0 is the outermost loop
// and NUM_LOOPS-1 is the innermost. When an outer loop branches back, every
// loop nested inside it is re-armed from its stored iteration count.
//
// Ports
//   clk_i, rst_i    clock, synchronous active-high reset
//   cfg_we_i        write one loop register set this cycle
//   cfg_sel_i       index of the loop register set to write
//   cfg_start_i     loop body first address
//   cfg_end_i       loop body last address
//   cfg_iter_i      iteration count N (0 = body runs once, no branch)
//   clear_i         deactivate all loops and zero their counters
//   step_i          the instruction at pc_i retires this cycle
//   pc_i            address of the retiring instruction
//   jump_o          branch to jump_addr_o instead of pc_i+1
//   jump_addr_o     branch target (0 when no loop wants to branch)
//   active_o        per-loop active flags
//   done_o          one-cycle pulse per loop when that loop exits
//   cnt_o           remaining-iteration counters, loop i at [i*CNTR_WIDTH +: CNTR_WIDTH]
//   cfg_err_o       one-cycle pulse after a write to a nonexistent loop index
// ---------------------------------------------------------------------------
module hwl_nested_engine #(
  parameter int NUM_LOOPS  = 3,
  parameter int CNTR_WIDTH = 10,
  parameter int ADDR_WIDTH = 6,
  localparam int SEL_W     = (NUM_LOOPS > 1) ? $clog2(NUM_LOOPS) : 1
) (
  input  logic                            clk_i,
  input  logic                            rst_i,
  input  logic                            cfg_we_i,
  input  logic [SEL_W-1:0]                cfg_sel_i,
  input  logic [ADDR_WIDTH-1:0]           cfg_start_i,
  input  logic [ADDR_WIDTH-1:0]           cfg_end_i,
  input  logic [CNTR_WIDTH-1:0]           cfg_iter_i,
  input  logic                            clear_i,
  input  logic                            step_i,
  input  logic [ADDR_WIDTH-1:0]           pc_i,
  output logic                            jump_o,
  output logic [ADDR_WIDTH-1:0]           jump_addr_o,
  output logic [NUM_LOOPS-1:0]            active_o,
  output logic [NUM_LOOPS-1:0]            done_o,
  output logic [NUM_LOOPS*CNTR_WIDTH-1:0] cnt_o,
  output logic                            cfg_err_o
);

  localparam logic [CNTR_WIDTH-1:0] CNT_ONE = CNTR_WIDTH'(1);

  logic [ADDR_WIDTH-1:0] startAddr_q [NUM_LOOPS];
  logic [ADDR_WIDTH-1:0] startAddr_d [NUM_LOOPS];
  logic [ADDR_WIDTH-1:0] endAddr_q   [NUM_LOOPS];
  logic [ADDR_WIDTH-1:0] endAddr_d   [NUM_LOOPS];
  logic [CNTR_WIDTH-1:0] iterCnt_q   [NUM_LOOPS];
  logic [CNTR_WIDTH-1:0] iterCnt_d   [NUM_LOOPS];
  logic [CNTR_WIDTH-1:0] loopCnt_q   [NUM_LOOPS];
  logic [CNTR_WIDTH-1:0] loopCnt_d   [NUM_LOOPS];
  logic [NUM_LOOPS-1:0]  active_q;
  logic [NUM_LOOPS-1:0]  active_d;
  logic [NUM_LOOPS-1:0]  done_q;
  logic [NUM_LOOPS-1:0]  done_d;
  logic                  cfgErr_q;
  logic                  cfgErr_d;

  logic [NUM_LOOPS-1:0]  cand;
  logic [NUM_LOOPS-1:0]  aboveK;
  logic                  hit;
  logic [SEL_W-1:0]      kIdx;
  logic [ADDR_WIDTH-1:0] jumpAddr;
  logic                  selValid;

  // When NUM_LOOPS is not a power of two the select field can name a loop
  // that does not exist; such writes are dropped and flagged.
  assign selValid = ({{(32-SEL_W){1'b0}}, cfg_sel_i} < NUM_LOOPS);

  // Branch decision. A loop is a candidate when it is active, its body ends
  // at the retiring PC and it still has iterations left. The innermost
  // candidate (highest index) wins because it is the loop the PC is
  // actually running inside. Loops nested inside the winner are marked so
  // the update logic can re-arm them.
  always_comb begin
    cand     = '0;
    aboveK   = '0;
    hit      = 1'b0;
    kIdx     = '0;
    jumpAddr = '0;
    for (int i = 0; i < NUM_LOOPS; i++) begin
      cand[i] = active_q[i] && (endAddr_q[i] == pc_i) && (loopCnt_q[i] != '0);
      if (cand[i]) begin
        hit      = 1'b1;
        kIdx     = SEL_W'(i);
        jumpAddr = startAddr_q[i];
      end
    end
    for (int i = 0; i < NUM_LOOPS; i++) begin
      aboveK[i] = hit && (SEL_W'(i) > kIdx);
    end
  end

  // Next-state logic. Clear wins over everything. Otherwise the retire-step
  // effects are applied first and a config write then overrides them for
  // the selected loop only. Exhausted loops inside the taken loop (or every
  // exhausted loop at this PC when nothing branches) exit and pulse done.
  // Re-arming happens after the exit and therefore takes priority over it,
  // while the done pulse for the exited loop is kept.
  always_comb begin
    startAddr_d = startAddr_q;
    endAddr_d   = endAddr_q;
    iterCnt_d   = iterCnt_q;
    loopCnt_d   = loopCnt_q;
    active_d    = active_q;
    done_d      = '0;
    cfgErr_d    = cfg_we_i && !selValid;

    for (int j = 0; j < NUM_LOOPS; j++) begin
      if (clear_i) begin
        loopCnt_d[j] = '0;
        active_d[j]  = 1'b0;
      end else begin
        if (step_i) begin
          if (hit && (SEL_W'(j) == kIdx)) begin
            loopCnt_d[j] = loopCnt_q[j] - CNT_ONE;
          end
          if (active_q[j] && (endAddr_q[j] == pc_i) && (loopCnt_q[j] == '0) &&
              (!hit || aboveK[j])) begin
            active_d[j] = 1'b0;
            done_d[j]   = 1'b1;
          end
          if (aboveK[j]) begin
            loopCnt_d[j] = (iterCnt_q[j] != '0) ? (iterCnt_q[j] - CNT_ONE) : '0;
            active_d[j]  = (iterCnt_q[j] != '0);
          end
        end

        if (cfg_we_i && selValid && (cfg_sel_i == SEL_W'(j))) begin
          startAddr_d[j] = cfg_start_i;
          endAddr_d[j]   = cfg_end_i;
          iterCnt_d[j]   = cfg_iter_i;
          loopCnt_d[j]   = (cfg_iter_i != '0) ? (cfg_iter_i - CNT_ONE) : '0;
          active_d[j]    = (cfg_iter_i != '0);
          done_d[j]      = 1'b0;
        end
      end
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      startAddr_q <= '{default: '0};
      endAddr_q   <= '{default: '0};
      iterCnt_q   <= '{default: '0};
      loopCnt_q   <= '{default: '0};
      active_q    <= '0;
      done_q      <= '0;
      cfgErr_q    <= 1'b0;
    end else begin
      startAddr_q <= startAddr_d;
      endAddr_q   <= endAddr_d;
      iterCnt_q   <= iterCnt_d;
      loopCnt_q   <= loopCnt_d;
      active_q    <= active_d;
      done_q      <= done_d;
      cfgErr_q    <= cfgErr_d;
    end
  end

  assign jump_o      = step_i && hit;
  assign jump_addr_o = jumpAddr;
  assign active_o    = active_q;
  assign done_o      = done_q;
  assign cfg_err_o   = cfgErr_q;

  for (genvar g = 0; g < NUM_LOOPS; g++) begin : g_cnt
    assign cnt_o[g*CNTR_WIDTH +: CNTR_WIDTH] = loopCnt_q[g];
  end

endmodule
